// File: rtl/control_sequencer.sv
// kwanCPU microcode sequencer: falling-edge step counter, halt latch and conditional-jump decode.
// Optional SEQ_EARLY_END_EN: restart at T0 as soon as the next microstep would be empty.
module control_sequencer #(
  parameter int NSTEPS = 5,
  parameter int OPW    = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           cf,
  input  logic           zf,
  output logic [2:0]     step,
  output logic           hlt,
  output logic           mi_,
  output logic           ri_,
  output logic           ro_,
  output logic           ii_,
  output logic           io_,
  output logic           ai_,
  output logic           ao_,
  output logic           bi_,
  output logic           eo_,
  output logic           su,
  output logic           fi_,
  output logic           oi,
  output logic           ce,
  output logic           co_,
  output logic           j_
);

  // Internal control word is active-high throughout; polarity is applied at the pins.
  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic ii;
    logic io;
    logic ai;
    logic ao;
    logic bi;
    logic eo;
    logic su;
    logic fi;
    logic oi;
    logic ce;
    logic co;
    logic j;
  } ctl_t;

  localparam logic [OPW-1:0] OP_LDA = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'h3);
  localparam logic [OPW-1:0] OP_STA = OPW'(4'h4);
  localparam logic [OPW-1:0] OP_LDI = OPW'(4'h5);
  localparam logic [OPW-1:0] OP_JMP = OPW'(4'h6);
  localparam logic [OPW-1:0] OP_JC  = OPW'(4'h7);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(4'h8);
  localparam logic [OPW-1:0] OP_OUT = OPW'(4'he);
  localparam logic [OPW-1:0] OP_HLT = OPW'(4'hf);

  function automatic ctl_t ucode(input logic [2:0] s, input logic [OPW-1:0] op,
                                 input logic c, input logic z);
    ctl_t w;
    w = '0;
    if (int'(s) < NSTEPS) begin
      case (s)
        3'd0: begin w.co = 1'b1; w.mi = 1'b1; end
        3'd1: begin w.ro = 1'b1; w.ii = 1'b1; w.ce = 1'b1; end
        3'd2: begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin w.io = 1'b1; w.mi = 1'b1; end
            OP_LDI: begin w.io = 1'b1; w.ai = 1'b1; end
            OP_JMP: begin w.io = 1'b1; w.j = 1'b1; end
            OP_JC:  begin w.io = c; w.j = c; end
            OP_JZ:  begin w.io = z; w.j = z; end
            OP_OUT: begin w.ao = 1'b1; w.oi = 1'b1; end
            OP_HLT: w.hlt = 1'b1;
            default: ;
          endcase
        end
        3'd3: begin
          case (op)
            OP_LDA:         begin w.ro = 1'b1; w.ai = 1'b1; end
            OP_ADD, OP_SUB: begin w.ro = 1'b1; w.bi = 1'b1; end
            OP_STA:         begin w.ao = 1'b1; w.ri = 1'b1; end
            default: ;
          endcase
        end
        3'd4: begin
          if (op == OP_ADD || op == OP_SUB) begin
            w.eo = 1'b1;
            w.ai = 1'b1;
            w.fi = 1'b1;
            w.su = (op == OP_SUB);
          end
        end
        default: ;
      endcase
    end
    return w;
  endfunction

  logic halted;
  logic last;
  logic early_end;
  ctl_t cur;
  ctl_t word;

  assign cur  = ucode(step, opcode, cf, zf);
  assign last = (step == 3'(NSTEPS - 1));

`ifdef SEQ_EARLY_END_EN
  // Flags are only meaningful in T2, so a conditional jump's T2 counts as occupied when looking ahead.
  assign early_end = (ucode(3'(step + 3'd1), opcode, 1'b1, 1'b1) == '0);
`else
  assign early_end = 1'b0;
`endif

  always_comb begin
    word = cur;
    if (halted) begin
      word     = '0;
      word.hlt = 1'b1;
    end
    if (rst) begin
      word = '0;
    end
  end

  // Falling-edge update gives the datapath a half cycle of settled controls before its rising edge.
  always_ff @(negedge clk) begin
    if (rst) begin
      step   <= 3'd0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (cur.hlt) begin
        halted <= 1'b1;
      end else if (last || early_end) begin
        step <= 3'd0;
      end else begin
        step <= 3'(step + 3'd1);
      end
    end
  end

  assign hlt = word.hlt;
  assign mi_ = ~word.mi;
  assign ri_ = ~word.ri;
  assign ro_ = ~word.ro;
  assign ii_ = ~word.ii;
  assign io_ = ~word.io;
  assign ai_ = ~word.ai;
  assign ao_ = ~word.ao;
  assign bi_ = ~word.bi;
  assign eo_ = ~word.eo;
  assign su  = word.su;
  assign fi_ = ~word.fi;
  assign oi  = word.oi;
  assign ce  = word.ce;
  assign co_ = ~word.co;
  assign j_  = ~word.j;

endmodule
